uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Memory-mapped, FIFO-buffered 8N1 UART transmitter; slave on the UART window of master_memory_map.
//  Consumes map_Data/map_Address/WSel_2 writes from the core's MEM stage; returns status on HRData2.
//  The FIFO decouples single-cycle sw stores from slow serial frames, so firmware can burst bytes
//  without polling busy per byte.
// PARAMETERS
//  DATA_WIDTH  32          bus width of wd/rd
//  CLK_FREQ    50_000_000  clk frequency, Hz
//  BAUD        115200      line rate; DIV = CLK_FREQ/BAUD (integer division, 434 at defaults)
//  FIFO_DEPTH  8           TX FIFO entries, power of 2, >=2
// PORTS
//  clk      in   1           system clock, all state on rising edge
//  rst_n    in   1           asynchronous active-low reset
//  wd       in   DATA_WIDTH  write data from memory map
//  address  in   DATA_WIDTH  byte address; only address[3:2] decoded
//  we       in   1           write strobe, one access per asserted cycle
//  rd       out  DATA_WIDTH  read data, combinational from address[3:2]
//  tx       out  1           serial line, registered, idle high
//  tx_busy  out  1           high while a frame is on the line or FIFO non-empty
// BEHAVIOUR
//  Register map (address[3:2]):
//   0 TXDATA  W: push wd[7:0] into FIFO; R: returns 0
//   1 STATUS  R: {.., cnt[7:4], ovf[3], busy[2], empty[1], full[0]}; W: wd[3]=1 clears ovf
//   2,3       reads 0, writes ignored
//  Reset (async): tx=1, FIFO empty (cnt=0), ovf=0, FSM IDLE, baud counter 0, tx_busy=0.
//   Reset mid-frame aborts the frame; tx returns high immediately, queued bytes are lost.
//  FIFO: wr/rd pointers of log2(FIFO_DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty compare MSB.
//   full/empty are evaluated on pre-edge state: a push while full is dropped and sets ovf,
//   even if a pop occurs the same cycle. Push and pop on the same edge otherwise both happen, cnt unchanged.
//  Baud: counter runs 0..DIV-1; bit_tick when counter==DIV-1; cleared on each frame start,
//   so every bit lasts exactly DIV clocks.
//  FSM:
//   IDLE : tx=1. If !empty: pop head into shift reg, counter=0, -> START.
//   START: tx=0 for DIV clocks -> DATA, bit index=0.
//   DATA : tx=shift[0], LSB first; on tick shift right, index++; after bit 7 -> STOP (or PARITY).
//   STOP : tx=1 for DIV clocks; on tick: if !empty pop and -> START directly (no idle gap), else -> IDLE.
//  Latency: TXDATA write at edge N into empty FIFO with FSM IDLE -> pop at edge N+1, tx=0 from N+1.
//  Frame length 10*DIV clocks (11*DIV with parity). Back-to-back frames are contiguous.
//  tx_busy = (state!=IDLE) | !empty.
//  Byte width: only wd[7:0] stored; wd[DATA_WIDTH-1:8] ignored.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, tx = ^byte (even
//   parity) for DIV clocks; frame 11*DIV clocks; STATUS bit[8] reads 1.
//  Not defined: 8N1 only, no PARITY state, STATUS bit[8] reads 0.
// TESTING
//  1 Reset: rst_n low mid-frame -> tx=1 same cycle, STATUS reads 0x002 (empty), tx_busy=0.
//  2 Write 0x55 to TXDATA at idle, DIV=434 -> tx low 1 clk after write edge; bits 1,0,1,0,1,0,1,0
//    LSB first, each 434 clks; stop high; tx_busy falls 4340 clks after frame start.
//  3 Burst 3 writes 0x41,0x42,0x43 back-to-back -> three contiguous frames, total 3*4340 clks,
//    no idle cycle between stop and next start; cnt reads 2 then 1 then 0 as bytes pop.
//  4 Overflow: frame in flight, push 9 bytes with DEPTH=8 -> 8 accepted, 9th dropped,
//    STATUS = full|ovf|busy, cnt=8; write STATUS wd=0x8 -> ovf=0.
//  5 Simultaneous push/pop: push on the exact edge STOP pops with FIFO full -> push dropped,
//    ovf=1; same edge with cnt=3 -> cnt stays 3, pushed byte sent in order.
//  6 UART_TX_PARITY_EN: send 0x07 -> parity bit 1, frame 4774 clks; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: memory-mapped 8N1 UART transmitter behind a TX FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing, STATUS[8]=1).
module uart_tx_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  tx,
  output logic                  tx_busy
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  localparam logic   PAR_EN     = 1'b1;
`else
  localparam state_t AFTER_DATA = STOP;
  localparam logic   PAR_EN     = 1'b0;
`endif
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d, ovf_q, ovf_d;
  logic [AW:0]   wptr_q, rptr_q, cnt;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          empty, full, tick, wr_data, wr_stat, push, pop;
  logic [8:0]    status;
  logic          unused_bits;

  assign cnt     = wptr_q - rptr_q;
  assign empty   = wptr_q == rptr_q;
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign tick    = baud_q == BAUD_LAST;
  assign wr_data = we && address[3:2] == 2'd0;
  assign wr_stat = we && address[3:2] == 2'd1;
  // full is judged on pre-edge state, so a push while full is dropped even if a pop frees a slot
  assign push    = wr_data && !full;
  assign pop     = !empty && (state_q == IDLE || (state_q == STOP && tick));
  assign tx_busy = (state_q != IDLE) || !empty;
  assign tx      = tx_q;
  assign status  = {PAR_EN, 4'(cnt), ovf_q, tx_busy, empty, full};
  assign rd      = (address[3:2] == 2'd1) ? DATA_WIDTH'(status) : '0;
  assign unused_bits = ^{wd[DATA_WIDTH-1:8], address[DATA_WIDTH-1:4], address[1:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    if (pop) begin
      state_d = START;
      idx_d   = '0;
      byte_d  = mem_q[rptr_q[AW-1:0]];
    end else if (tick) begin
      case (state_q)
        START:   state_d = DATA;
        DATA: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = AFTER_DATA;
        end
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
    tx_d  = (state_d == START)  ? 1'b0 :
            (state_d == DATA)   ? byte_d[idx_d] :
            (state_d == PARITY) ? ^byte_d : 1'b1;
    ovf_d = (wr_data && full) ? 1'b1 : (wr_stat && wd[3]) ? 1'b0 : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wd[7:0];
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based line model.
module tb_uart_tx_buffered;
  localparam int DIV   = 8;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PB = 32'h100;
`else
  localparam int NB = 10;
  localparam logic [31:0] PB = 32'h0;
`endif

  logic clk = 0, rst_n = 0, we = 0, tx, tx_busy;
  logic [31:0] wd = 0, address = 0, rd;
  int checks = 0, errors = 0;

  uart_tx_buffered #(.DATA_WIDTH(32), .CLK_FREQ(DIV * 100), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wd(wd), .address(address), .we(we),
    .rd(rd), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic       line[$];
  logic       m_ovf, m_inf, m_tx;

  function automatic void m_reset();
    q.delete();
    line.delete();
    m_ovf = 0;
    m_inf = 0;
    m_tx  = 1;
  endfunction

  function automatic void m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic       full_pre;
    logic [7:0] b;
    logic       v;
    full_pre = q.size() == DEPTH;
    if (line.size() == 0 && q.size() > 0) begin
      b = q.pop_front();
      for (int k = 0; k < NB; k++) begin
        v = (k == 0) ? 1'b0 : (k < 9) ? b[k-1] : (NB == 11 && k == 9) ? ^b : 1'b1;
        for (int j = 0; j < DIV; j++) line.push_back(v);
      end
    end
    m_inf = line.size() > 0;
    m_tx  = m_inf ? line.pop_front() : 1'b1;
    if (w && a[3:2] == 2'd0) begin
      if (full_pre) m_ovf = 1;
      else q.push_back(d[7:0]);
    end else if (w && a[3:2] == 2'd1 && d[3]) m_ovf = 0;
  endfunction

  function automatic logic m_busy();
    return m_inf || q.size() > 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] s;
    s = PB | (q.size() << 4) | {28'd0, m_ovf, m_busy(), q.size() == 0, q.size() == DEPTH};
    return (a[3:2] == 2'd1) ? s : 32'd0;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; address = a; wd = d;
    m_step(w, a, d);
    @(posedge clk);
    @(negedge clk);
    chk("tx", {31'd0, tx}, {31'd0, m_tx});
    chk("busy", {31'd0, tx_busy}, {31'd0, m_busy()});
    chk("rd", rd, m_rd(a));
    we = 0;
  endtask

  typedef struct {
    logic w; logic [31:0] a; logic [31:0] d; logic [31:0] rd_e; logic tx_e; logic busy_e;
  } vec_t;
  vec_t tv[9];

  initial begin
    int n;
    logic [31:0] r;
    tv[0] = '{0, 32'h4, 32'h0,        PB | 32'h002, 1, 0};
    tv[1] = '{0, 32'h0, 32'h0,        32'h0,        1, 0};
    tv[2] = '{0, 32'h8, 32'h0,        32'h0,        1, 0};
    tv[3] = '{0, 32'hC, 32'h0,        32'h0,        1, 0};
    tv[4] = '{1, 32'h4, 32'h8,        PB | 32'h002, 1, 0};
    tv[5] = '{1, 32'h8, 32'h41,       32'h0,        1, 0};
    tv[6] = '{1, 32'h0, 32'hABCD0155, 32'h0,        1, 1};
    tv[7] = '{0, 32'h4, 32'h0,        PB | 32'h006, 0, 1};
    tv[8] = '{0, 32'h4, 32'h0,        PB | 32'h006, 0, 1};

    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    rst_n = 1;

    for (int i = 0; i < 9; i++) begin
      cyc(tv[i].w, tv[i].a, tv[i].d);
      chk("vec_rd", rd, tv[i].rd_e);
      chk("vec_tx", {31'd0, tx}, {31'd0, tv[i].tx_e});
      chk("vec_busy", {31'd0, tx_busy}, {31'd0, tv[i].busy_e});
    end
    n = 2;
    for (int i = 0; i < 2000 && tx_busy; i++) begin
      cyc(0, 32'h4, 0);
      if (tx_busy) n++;
    end
    chk("frame_len", n, NB * DIV);

    cyc(1, 0, 32'h41); cyc(1, 0, 32'h42); cyc(1, 0, 32'h43);
    n = 0;
    for (int i = 0; i < 5000 && tx_busy; i++) begin
      cyc(0, 32'h4, 0);
      if (tx_busy) n++;
    end
    chk("burst_len", n, 3 * NB * DIV - 2);

    cyc(1, 0, 32'h11); cyc(0, 32'h4, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 32'h20 + i);
    cyc(0, 32'h4, 0);
    chk("ovf_status", rd, PB | 32'h08D);
    cyc(1, 32'h4, 32'h8);
    chk("ovf_clear", rd, PB | 32'h085);

    n = 0;
    while (!(line.size() == 0 && q.size() == DEPTH) && n < 3000) begin cyc(0, 32'h4, 0); n++; end
    chk("full_pop_reached", {31'd0, n < 3000}, 32'd1);
    cyc(1, 0, 32'hEE);
    chk("full_pop_status", rd, 32'h0);
    cyc(0, 32'h4, 0);
    chk("full_pop_drop", rd & 32'hFF, 32'h07C);
    cyc(1, 32'h4, 32'h8);
    n = 0;
    while (!(line.size() == 0 && q.size() == 3) && n < 3000) begin cyc(0, 32'h4, 0); n++; end
    chk("cnt3_pop_reached", {31'd0, n < 3000}, 32'd1);
    cyc(1, 32'h0, 32'h99);
    cyc(0, 32'h4, 0);
    chk("cnt3_pop_push", rd, PB | 32'h034);
    for (int i = 0; i < 3000 && tx_busy; i++) cyc(0, 32'h4, 0);
    chk("drained", {31'd0, tx_busy}, 32'd0);

    cyc(1, 0, 32'h3C);
    repeat (DIV + 3) cyc(0, 32'h4, 0);
    rst_n = 0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_status", rd, PB | 32'h002);
    m_reset();
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 5000; i++) begin
      r = $urandom_range(0, 999);
      if (r == 999) begin
        rst_n = 0;
        #1;
        chk("rand_rst_tx", {31'd0, tx}, 32'd1);
        m_reset();
        @(negedge clk);
        rst_n = 1;
      end else if (r < 40) cyc(1, 32'h0, $urandom);
      else if (r < 55) cyc(1, 32'h4, $urandom);
      else if (r < 70) cyc(1, {28'd0, 2'($urandom_range(2, 3)), 2'b00}, $urandom);
      else cyc(0, {28'd0, 2'($urandom_range(0, 3)), 2'b00}, 0);
    end
    for (int i = 0; i < 2000 && tx_busy; i++) cyc(0, 32'h4, 0);
    chk("final_idle", {31'd0, tx_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
